// File: rtl/vec_pkg.sv
// vec_pkg: shared widths and types for the vector execute stage
package vec_pkg;
   localparam int VEC_W = 256;
   localparam int LANE_W = 8;
   localparam int NUM_LANES = 32;
   typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SHL, MUL, PASS} alu_op_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} exec_state_t;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;
endpackage

// File: rtl/vec_exec_stage_if.sv
// vec_exec_stage_if: E-stage inputs and M-stage outputs of the vector execute stage
interface vec_exec_stage_if;
   import vec_pkg::*;
   logic             valid_e;
   logic [VEC_W-1:0] rdo1;
   logic [VEC_W-1:0] rdo2;
   logic [VEC_W-1:0] exto;
   logic [2:0]       ao3;
   logic             ALUSrcE;
   logic [2:0]       ALUControlE;
   logic             RegWriteE;
   logic             MemtoRegE;
   logic             MemWriteE;
   logic             stall_e;
   logic             valid_m;
   logic [VEC_W-1:0] ALUResultM;
   logic [VEC_W-1:0] WriteDataM;
   logic [2:0]       WA3M;
   logic             RegWriteM;
   logic             MemtoRegM;
   logic             MemWriteM;
   logic [3:0]       FlagsM;
   modport slave (
      input  valid_e, rdo1, rdo2, exto, ao3, ALUSrcE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE,
      output stall_e, valid_m, ALUResultM, WriteDataM, WA3M, RegWriteM, MemtoRegM, MemWriteM, FlagsM
   );
   modport master (
      output valid_e, rdo1, rdo2, exto, ao3, ALUSrcE, ALUControlE, RegWriteE, MemtoRegE, MemWriteE,
      input  stall_e, valid_m, ALUResultM, WriteDataM, WA3M, RegWriteM, MemtoRegM, MemWriteM, FlagsM
   );
endinterface

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: one 8-bit lane with carry/no-borrow and signed overflow
module vec_lane_alu
   import vec_pkg::*;
(
   input  logic [LANE_W-1:0] a_i,
   input  logic [LANE_W-1:0] b_i,
   input  alu_op_t           op_i,
   output logic [LANE_W-1:0] res_o,
   output logic              c_o,
   output logic              v_o
);
   logic [LANE_W:0] sum;
   logic [LANE_W:0] dif;
   always_comb begin
      sum = {1'b0, a_i} + {1'b0, b_i};
      dif = {1'b0, a_i} - {1'b0, b_i};
      res_o = op_i == ADD ? sum[LANE_W-1:0] :
              op_i == SUB ? dif[LANE_W-1:0] :
              op_i == AND ? a_i & b_i :
              op_i == OR  ? a_i | b_i :
              op_i == XOR ? a_i ^ b_i :
              op_i == SHL ? a_i << b_i[2:0] :
              op_i == MUL ? a_i * b_i : b_i;
      c_o = op_i == ADD ? sum[LANE_W] : op_i == SUB ? ~dif[LANE_W] : 1'b0;
      v_o = op_i == ADD ? (a_i[LANE_W-1] == b_i[LANE_W-1]) & (sum[LANE_W-1] != a_i[LANE_W-1]) :
            op_i == SUB ? (a_i[LANE_W-1] != b_i[LANE_W-1]) & (dif[LANE_W-1] != a_i[LANE_W-1]) : 1'b0;
   end
endmodule

// File: rtl/vec_exec_stage.sv
// vec_exec_stage: multi-cycle 32x8-bit vector ALU between D/E and E/M registers
module vec_exec_stage
   import vec_pkg::*;
#(
   parameter int LANES_PER_CYCLE = 8
) (
   input logic              clk,
   input logic              reset,
   vec_exec_stage_if.slave  bus
);
   localparam int NUM_CHUNKS = NUM_LANES / LANES_PER_CYCLE;
   localparam int CW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
   localparam int CHUNK_W = LANES_PER_CYCLE * LANE_W;
   localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

   exec_state_t          state_q, state_d;
   logic [CW-1:0]        chunk_q, chunk_d;
   logic [VEC_W-1:0]     a_q, b_q, wd_q, res_q, res_d, alu_res_q, wd_m_q;
   logic [2:0]           wa_q, wa_m_q;
   alu_op_t              op_q;
   logic                 rw_q, m2r_q, mw_q, m2r_m_q, c_acc_q, v_acc_q;
   flags_t               flags_q, flags_d;
   logic                 accept, last, run, stall;
   logic [CHUNK_W-1:0]   ca, cb, cr;
   logic [LANES_PER_CYCLE-1:0] lc, lv;

   assign ca = a_q[int'(chunk_q) * CHUNK_W +: CHUNK_W];
   assign cb = b_q[int'(chunk_q) * CHUNK_W +: CHUNK_W];

   for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
      vec_lane_alu u_alu (
         .a_i   (ca[g*LANE_W +: LANE_W]),
         .b_i   (cb[g*LANE_W +: LANE_W]),
         .op_i  (op_q),
         .res_o (cr[g*LANE_W +: LANE_W]),
         .c_o   (lc[g]),
         .v_o   (lv[g])
      );
   end

   // accept is possible from IDLE and DONE; reset masks it and the stall
   always_comb begin
      run = state_q == RUN;
      last = run && chunk_q == LAST;
      accept = !reset && bus.valid_e && !run;
      state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
      chunk_d = (run && !last) ? chunk_q + 1'b1 : '0;
      stall = accept || (!reset && run && !last);
   end

   always_comb begin
      res_d = res_q;
      res_d[int'(chunk_q) * CHUNK_W +: CHUNK_W] = cr;
      flags_d.c = c_acc_q | (|lc);
      flags_d.v = v_acc_q | (|lv);
      flags_d.z = res_d == '0;
      flags_d.n = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) flags_d.n = flags_d.n | res_d[i*LANE_W + LANE_W-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         chunk_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         wd_q      <= '0;
         wa_q      <= '0;
         op_q      <= ADD;
         rw_q      <= 1'b0;
         m2r_q     <= 1'b0;
         mw_q      <= 1'b0;
         c_acc_q   <= 1'b0;
         v_acc_q   <= 1'b0;
         res_q     <= '0;
         alu_res_q <= '0;
         wd_m_q    <= '0;
         wa_m_q    <= '0;
         m2r_m_q   <= 1'b0;
         flags_q   <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         if (accept) begin
            a_q     <= bus.rdo1;
            b_q     <= bus.ALUSrcE ? bus.exto : bus.rdo2;
            wd_q    <= bus.rdo2;
            wa_q    <= bus.ao3;
            op_q    <= alu_op_t'(bus.ALUControlE);
            rw_q    <= bus.RegWriteE;
            m2r_q   <= bus.MemtoRegE;
            mw_q    <= bus.MemWriteE;
            c_acc_q <= 1'b0;
            v_acc_q <= 1'b0;
         end
         if (run) begin
            res_q   <= res_d;
            c_acc_q <= flags_d.c;
            v_acc_q <= flags_d.v;
         end
         if (last) begin
            alu_res_q <= res_d;
            wd_m_q    <= wd_q;
            wa_m_q    <= wa_q;
            m2r_m_q   <= m2r_q;
            flags_q   <= flags_d;
         end
      end
   end

   assign bus.stall_e    = stall;
   assign bus.valid_m    = state_q == DONE;
   assign bus.ALUResultM = alu_res_q;
   assign bus.WriteDataM = wd_m_q;
   assign bus.WA3M       = wa_m_q;
   assign bus.MemtoRegM  = m2r_m_q;
   assign bus.FlagsM     = flags_q;
   assign bus.RegWriteM  = (state_q == DONE) & rw_q;
   assign bus.MemWriteM  = (state_q == DONE) & mw_q;
endmodule

// File: tb/tb_vec_exec_stage.sv
// tb_vec_exec_stage: directed vectors checked against a lane-level model every cycle
module tb_vec_exec_stage;
   import vec_pkg::*;
   localparam int NC = 4;

   typedef struct {
      int               due;
      logic [VEC_W-1:0] res;
      logic [VEC_W-1:0] wd;
      logic [2:0]       wa;
      logic             rw;
      logic             m2r;
      logic             mw;
      logic [3:0]       fl;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_acc = -100;
   bit   started = 1'b0;
   logic exp_v;
   exp_t exp_q[$];
   exp_t held;

   vec_exec_stage_if bus();
   vec_exec_stage_if bus32();

   vec_exec_stage #(.LANES_PER_CYCLE(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   vec_exec_stage #(.LANES_PER_CYCLE(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, want);
      end
   endtask

   function automatic logic [VEC_W-1:0] model_res(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input logic [2:0] op);
      logic [VEC_W-1:0] r;
      int x, y, z;
      r = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         x = int'(a[8*i +: 8]);
         y = int'(b[8*i +: 8]);
         case (op)
            3'd0: z = x + y;
            3'd1: z = x - y;
            3'd2: z = x & y;
            3'd3: z = x | y;
            3'd4: z = x ^ y;
            3'd5: z = x << (y % 8);
            3'd6: z = x * y;
            default: z = y;
         endcase
         r[8*i +: 8] = z[7:0];
      end
      return r;
   endfunction

   function automatic logic [3:0] model_flags(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input logic [2:0] op, input logic [VEC_W-1:0] r);
      logic n, c, v;
      int x, y, sx, sy;
      n = 1'b0;
      c = 1'b0;
      v = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         x = int'(a[8*i +: 8]);
         y = int'(b[8*i +: 8]);
         sx = x > 127 ? x - 256 : x;
         sy = y > 127 ? y - 256 : y;
         n = n | r[8*i+7];
         if (op == 3'd0) begin
            c = c | (x + y > 255);
            v = v | (sx + sy > 127 || sx + sy < -128);
         end
         if (op == 3'd1) begin
            c = c | (x >= y);
            v = v | (sx - sy > 127 || sx - sy < -128);
         end
      end
      return {n, r == '0, c, v};
   endfunction

   function automatic logic [VEC_W-1:0] rnd_vec();
      logic [VEC_W-1:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      last_acc = -100;
      held.due = 0;
      held.res = '0;
      held.wd = '0;
      held.wa = '0;
      held.rw = 1'b0;
      held.m2r = 1'b0;
      held.mw = 1'b0;
      held.fl = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_model();
      step(1);
      reset = 1'b0;
   endtask

   // presents one instruction for a single cycle, then scrambles the E inputs
   task automatic issue(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input logic [VEC_W-1:0] e,
                        input logic src, input logic [2:0] op, input logic [2:0] wa,
                        input logic rw, input logic m2r, input logic mw);
      exp_t t;
      logic [VEC_W-1:0] bb;
      bb = src ? e : b;
      t.due = cyc + NC + 1;
      t.res = model_res(a, bb, op);
      t.fl = model_flags(a, bb, op, t.res);
      t.wd = b;
      t.wa = wa;
      t.rw = rw;
      t.m2r = m2r;
      t.mw = mw;
      exp_q.push_back(t);
      last_acc = cyc;
      bus.valid_e = 1'b1;
      bus.rdo1 = a;
      bus.rdo2 = b;
      bus.exto = e;
      bus.ao3 = wa;
      bus.ALUSrcE = src;
      bus.ALUControlE = op;
      bus.RegWriteE = rw;
      bus.MemtoRegE = m2r;
      bus.MemWriteE = mw;
      step(1);
      bus.valid_e = 1'b0;
      bus.rdo1 = ~a;
      bus.rdo2 = ~b;
      bus.exto = ~e;
      bus.ao3 = ~wa;
      bus.ALUSrcE = ~src;
      bus.ALUControlE = ~op;
      bus.RegWriteE = ~rw;
      bus.MemtoRegE = ~m2r;
      bus.MemWriteE = ~mw;
   endtask

   always @(negedge clk) begin
      if (started && !reset) begin
         exp_v = exp_q.size() > 0 && exp_q[0].due == cyc;
         if (exp_v) held = exp_q.pop_front();
         chk("valid_m", VEC_W'(bus.valid_m), VEC_W'(exp_v));
         chk("stall_e", VEC_W'(bus.stall_e), VEC_W'(cyc >= last_acc && cyc < last_acc + NC));
         chk("ALUResultM", bus.ALUResultM, held.res);
         chk("WriteDataM", bus.WriteDataM, held.wd);
         chk("WA3M", VEC_W'(bus.WA3M), VEC_W'(held.wa));
         chk("MemtoRegM", VEC_W'(bus.MemtoRegM), VEC_W'(held.m2r));
         chk("FlagsM", VEC_W'(bus.FlagsM), VEC_W'(held.fl));
         chk("RegWriteM", VEC_W'(bus.RegWriteM), VEC_W'(exp_v & held.rw));
         chk("MemWriteM", VEC_W'(bus.MemWriteM), VEC_W'(exp_v & held.mw));
      end
   end

   initial begin
      logic [VEC_W-1:0] ra, rb, re, b3;
      bus.valid_e = 1'b0;
      bus.rdo1 = '0;
      bus.rdo2 = '0;
      bus.exto = '0;
      bus.ao3 = '0;
      bus.ALUSrcE = 1'b0;
      bus.ALUControlE = '0;
      bus.RegWriteE = 1'b0;
      bus.MemtoRegE = 1'b0;
      bus.MemWriteE = 1'b0;
      bus32.valid_e = 1'b0;
      bus32.rdo1 = '0;
      bus32.rdo2 = '0;
      bus32.exto = '0;
      bus32.ao3 = '0;
      bus32.ALUSrcE = 1'b0;
      bus32.ALUControlE = '0;
      bus32.RegWriteE = 1'b0;
      bus32.MemtoRegE = 1'b0;
      bus32.MemWriteE = 1'b0;
      clear_model();
      step(2);
      reset = 1'b0;
      started = 1'b1;
      step(1);
      chk("reset ALUResultM", bus.ALUResultM, '0);
      chk("reset FlagsM", VEC_W'(bus.FlagsM), '0);
      chk("model add", model_res({32{8'h10}}, {32{8'h22}}, 3'd0), {32{8'h32}});
      chk("model add flags", VEC_W'(model_flags({32{8'hFF}}, {32{8'h01}}, 3'd0, model_res({32{8'hFF}}, {32{8'h01}}, 3'd0))), VEC_W'(4'b0110));
      chk("model sub flags", VEC_W'(model_flags({32{8'h00}}, {32{8'h01}}, 3'd1, model_res({32{8'h00}}, {32{8'h01}}, 3'd1))), VEC_W'(4'b1000));
      chk("model shl", model_res({32{8'h81}}, {32{8'h03}}, 3'd5), {32{8'h08}});
      // basic add: pulse lands NC cycles after the accept cycle ends
      issue({32{8'h10}}, {32{8'h22}}, '0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
      step(NC);
      chk("t1 valid_m", VEC_W'(bus.valid_m), VEC_W'(1'b1));
      chk("t1 result", bus.ALUResultM, {32{8'h32}});
      chk("t1 flags", VEC_W'(bus.FlagsM), VEC_W'(4'b0000));
      step(1);
      chk("t1 RegWriteM drop", VEC_W'(bus.RegWriteM), '0);
      issue({32{8'hFF}}, {32{8'h01}}, '0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
      step(NC);
      chk("t2 add flags", VEC_W'(bus.FlagsM), VEC_W'(4'b0110));
      step(1);
      issue({32{8'h00}}, {32{8'h01}}, '0, 1'b0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);
      step(NC);
      chk("t2 sub result", bus.ALUResultM, {32{8'hFF}});
      chk("t2 sub flags", VEC_W'(bus.FlagsM), VEC_W'(4'b1000));
      step(1);
      b3 = rnd_vec();
      issue({32{8'h81}}, b3, {32{8'h03}}, 1'b1, 3'd5, 3'd5, 1'b0, 1'b1, 1'b1);
      step(NC);
      chk("t3 result", bus.ALUResultM, {32{8'h08}});
      chk("t3 WriteDataM", bus.WriteDataM, b3);
      chk("t3 MemWriteM", VEC_W'(bus.MemWriteM), VEC_W'(1'b1));
      step(1);
      // back-to-back: second instruction presented in the DONE cycle
      issue(rnd_vec(), rnd_vec(), '0, 1'b0, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0);
      step(NC);
      chk("t4 WA3M first", VEC_W'(bus.WA3M), VEC_W'(3'd2));
      issue(rnd_vec(), rnd_vec(), '0, 1'b0, 3'd4, 3'd6, 1'b1, 1'b1, 1'b0);
      step(NC);
      chk("t4 WA3M second", VEC_W'(bus.WA3M), VEC_W'(3'd6));
      step(1);
      for (int k = 0; k < 8; k++) begin
         ra = rnd_vec();
         rb = rnd_vec();
         re = rnd_vec();
         issue(ra, rb, re, k[0], k[2:0], k[2:0], k[1], k[2], k[0]);
         step(NC + 1);
      end
      // reset in the second RUN cycle discards the instruction
      issue(rnd_vec(), rnd_vec(), '0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b1, 1'b1);
      step(1);
      do_reset();
      chk("t5 stall after reset", VEC_W'(bus.stall_e), '0);
      chk("t5 result cleared", bus.ALUResultM, '0);
      step(NC + 2);
      issue({32{8'h05}}, {32{8'h03}}, '0, 1'b0, 3'd6, 3'd4, 1'b1, 1'b0, 1'b0);
      step(NC);
      chk("t5 recovery result", bus.ALUResultM, {32{8'h0F}});
      step(1);
      // single-chunk variant: stall only in the accept cycle
      bus32.valid_e = 1'b1;
      bus32.rdo1 = {32{8'hA5}};
      bus32.rdo2 = {32{8'hA5}};
      bus32.ALUControlE = 3'd4;
      bus32.RegWriteE = 1'b1;
      @(negedge clk);
      chk("t6 accept stall", VEC_W'(bus32.stall_e), VEC_W'(1'b1));
      @(posedge clk);
      #1;
      bus32.valid_e = 1'b0;
      @(negedge clk);
      chk("t6 run stall", VEC_W'(bus32.stall_e), '0);
      chk("t6 run valid", VEC_W'(bus32.valid_m), '0);
      @(negedge clk);
      chk("t6 done valid", VEC_W'(bus32.valid_m), VEC_W'(1'b1));
      chk("t6 result", bus32.ALUResultM, '0);
      chk("t6 flags", VEC_W'(bus32.FlagsM), VEC_W'(4'b0100));
      chk("t6 RegWriteM", VEC_W'(bus32.RegWriteM), VEC_W'(1'b1));
      @(negedge clk);
      chk("t6 idle valid", VEC_W'(bus32.valid_m), '0);
      step(3);
      chk("pending pulses", VEC_W'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
